// File: rtl/expr_result_unpacker.sv
// Unpacks one 90-bit expression-result word into 18 extended fields, MSB field
// first, and reports the XOR of the extended fields once the word is drained.
module expr_result_unpacker #(
  parameter int EXT_W      = 8,
  parameter int NUM_FIELDS = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [89:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_idx,
  output logic [EXT_W-1:0] out_field,
  output logic             out_last,
  output logic             sum_valid,
  output logic [EXT_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_FIELDS - 1);

  state_t           state_reg;
  logic [89:0]      data_reg;
  logic [4:0]       idx_reg;
  logic [EXT_W-1:0] acc_reg;
  logic [89:0]      src;
  logic [4:0]       idx_next;
  logic [EXT_W-1:0] ext_fields [32];

  // In IDLE the field mux looks at the incoming word so field 0 can be
  // registered on the accepting edge; afterwards it looks at the stored word.
  assign src      = (state_reg == IDLE) ? in_data : data_reg;
  assign idx_next = (state_reg == IDLE) ? 5'd0 : idx_reg + 5'd1;
  assign out_idx  = idx_reg;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_field
      if (gi < NUM_FIELDS) begin : g_real
        localparam int P   = gi % 6;
        localparam int G   = gi / 6;
        localparam int W   = (P % 3 == 0) ? 4 : ((P % 3 == 1) ? 5 : 6);
        localparam int OFF = (P / 3) * 15 + ((P % 3 == 0) ? 0 : ((P % 3 == 1) ? 4 : 9));
        localparam int LSB = 90 - 30 * G - OFF - W;
        logic [W-1:0] raw;
        assign raw = src[LSB +: W];
        // Positions 3..5 of each group carry signed quantities.
        if (P >= 3) begin : g_sext
          assign ext_fields[gi] = EXT_W'($signed(raw));
        end else begin : g_zext
          assign ext_fields[gi] = EXT_W'(raw);
        end
      end else begin : g_pad
        assign ext_fields[gi] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      idx_reg   <= '0;
      acc_reg   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_field <= '0;
      sum_valid <= 1'b0;
      checksum  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          sum_valid <= 1'b0;
          if (in_valid) begin
            data_reg  <= in_data;
            idx_reg   <= 5'd0;
            acc_reg   <= '0;
            out_field <= ext_fields[idx_next];
            out_last  <= (idx_next == LAST_IDX);
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            state_reg <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            acc_reg <= acc_reg ^ out_field;
            if (idx_reg == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              sum_valid <= 1'b1;
              checksum  <= acc_reg ^ out_field;
              state_reg <= DONE;
            end else begin
              idx_reg   <= idx_next;
              out_field <= ext_fields[idx_next];
              out_last  <= (idx_next == LAST_IDX);
            end
          end
        end
        DONE: begin
          sum_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Directed bench for expr_result_unpacker: pattern words, backpressure,
// mid-word reset and back-to-back acceptance with hand-computed expectations.
module tb_expr_result_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [89:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [7:0]  out_field;
  logic        out_last;
  logic        sum_valid;
  logic [7:0]  checksum;

  int checks = 0;
  int errors = 0;

  // Extended value of each group position when every input bit is 1.
  logic [7:0] ones_tab [6] = '{8'h0F, 8'h1F, 8'h3F, 8'hFF, 8'hFF, 8'hFF};

  logic [7:0] obs_field [18];
  logic [4:0] obs_idx   [18];
  logic       obs_valid [18];
  logic       obs_last  [18];
  logic [4:0] stall_idx_obs   [8];
  logic [7:0] stall_field_obs [8];
  logic       stall_valid_obs [8];
  int         obs_done_wait;
  logic [7:0] obs_checksum;
  logic       obs_ready_done;
  logic       obs_ready_after;
  logic       obs_sum_after;

  expr_result_unpacker #(.EXT_W(8), .NUM_FIELDS(18)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_field (out_field),
    .out_last  (out_last),
    .sum_valid (sum_valid),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  // Sends one word and records what the DUT shows; comparisons live in the tests.
  task automatic capture_word(input logic [89:0] d, input int stall_at, input int stall_len);
    @(negedge clk);
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      obs_field[k] = out_field;
      obs_idx[k]   = out_idx;
      obs_valid[k] = out_valid;
      obs_last[k]  = out_last;
      if (k == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          stall_idx_obs[s]   = out_idx;
          stall_field_obs[s] = out_field;
          stall_valid_obs[s] = out_valid;
        end
        out_ready = 1'b1;
      end
    end
    obs_done_wait  = -1;
    obs_checksum   = 8'h00;
    obs_ready_done = 1'b1;
    for (int w = 1; w <= 4 && obs_done_wait < 0; w++) begin
      @(negedge clk);
      if (sum_valid) begin
        obs_done_wait  = w;
        obs_checksum   = checksum;
        obs_ready_done = in_ready;
      end
    end
    @(negedge clk);
    obs_ready_after = in_ready;
    obs_sum_after   = sum_valid;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 7;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    if (out_idx !== 5'd0) begin errors++; $display("FAIL reset_out_idx got=%0d want=0", out_idx); end
    if (out_field !== 8'h00) begin errors++; $display("FAIL reset_out_field got=%h want=00", out_field); end
    if (sum_valid !== 1'b0) begin errors++; $display("FAIL reset_sum_valid got=%b want=0", sum_valid); end
    if (checksum !== 8'h00) begin errors++; $display("FAIL reset_checksum got=%h want=00", checksum); end
    $display("test_reset: done");
  endtask

  task automatic test_zeros();
    capture_word(90'd0, -1, 0);
    for (int k = 0; k < 18; k++) begin
      checks += 4;
      if (obs_valid[k] !== 1'b1) begin errors++; $display("FAIL zeros_valid[%0d] got=%b want=1", k, obs_valid[k]); end
      if (obs_idx[k] !== 5'(k)) begin errors++; $display("FAIL zeros_idx[%0d] got=%0d want=%0d", k, obs_idx[k], k); end
      if (obs_field[k] !== 8'h00) begin errors++; $display("FAIL zeros_field[%0d] got=%h want=00", k, obs_field[k]); end
      if (obs_last[k] !== (k == 17)) begin errors++; $display("FAIL zeros_last[%0d] got=%b want=%b", k, obs_last[k], k == 17); end
    end
    checks += 5;
    if (obs_done_wait !== 1) begin errors++; $display("FAIL zeros_sum_delay got=%0d want=1", obs_done_wait); end
    if (obs_checksum !== 8'h00) begin errors++; $display("FAIL zeros_checksum got=%h want=00", obs_checksum); end
    if (obs_ready_done !== 1'b0) begin errors++; $display("FAIL zeros_ready_in_done got=%b want=0", obs_ready_done); end
    if (obs_ready_after !== 1'b1) begin errors++; $display("FAIL zeros_ready_after got=%b want=1", obs_ready_after); end
    if (obs_sum_after !== 1'b0) begin errors++; $display("FAIL zeros_sum_pulse_len got=%b want=0", obs_sum_after); end
    $display("test_zeros: checksum=%h", obs_checksum);
  endtask

  task automatic test_msb_field();
    logic [89:0] d;
    logic [7:0]  exp;
    d = '0;
    d[89:86] = 4'hF;
    capture_word(d, -1, 0);
    for (int k = 0; k < 18; k++) begin
      exp = (k == 0) ? 8'h0F : 8'h00;
      checks++;
      if (obs_field[k] !== exp) begin errors++; $display("FAIL msb_field[%0d] got=%h want=%h", k, obs_field[k], exp); end
    end
    checks++;
    if (obs_checksum !== 8'h0F) begin errors++; $display("FAIL msb_checksum got=%h want=0f", obs_checksum); end
    $display("test_msb_field: checksum=%h", obs_checksum);
  endtask

  task automatic test_sign_bit();
    logic [89:0] d;
    logic [7:0]  exp;
    d = '0;
    d[74] = 1'b1;
    capture_word(d, -1, 0);
    for (int k = 0; k < 18; k++) begin
      exp = (k == 3) ? 8'hF8 : 8'h00;
      checks++;
      if (obs_field[k] !== exp) begin errors++; $display("FAIL sign_field[%0d] got=%h want=%h", k, obs_field[k], exp); end
    end
    checks++;
    if (obs_checksum !== 8'hF8) begin errors++; $display("FAIL sign_checksum got=%h want=f8", obs_checksum); end
    $display("test_sign_bit: checksum=%h", obs_checksum);
  endtask

  // Field 2 = 6'h20 (zero-ext), field 4 = 5'h10 (sign-ext), field 17 = 6'h21 (sign-ext).
  task automatic test_mixed();
    logic [89:0] d;
    logic [7:0]  exp;
    d = '0;
    d[80] = 1'b1;
    d[70] = 1'b1;
    d[5]  = 1'b1;
    d[0]  = 1'b1;
    capture_word(d, -1, 0);
    for (int k = 0; k < 18; k++) begin
      exp = (k == 2) ? 8'h20 : (k == 4) ? 8'hF0 : (k == 17) ? 8'hE1 : 8'h00;
      checks++;
      if (obs_field[k] !== exp) begin errors++; $display("FAIL mixed_field[%0d] got=%h want=%h", k, obs_field[k], exp); end
    end
    checks++;
    if (obs_checksum !== 8'h31) begin errors++; $display("FAIL mixed_checksum got=%h want=31", obs_checksum); end
    $display("test_mixed: checksum=%h", obs_checksum);
  endtask

  task automatic test_all_ones();
    capture_word({90{1'b1}}, -1, 0);
    for (int k = 0; k < 18; k++) begin
      checks++;
      if (obs_field[k] !== ones_tab[k % 6]) begin
        errors++; $display("FAIL ones_field[%0d] got=%h want=%h", k, obs_field[k], ones_tab[k % 6]);
      end
    end
    checks++;
    if (obs_checksum !== 8'hD0) begin errors++; $display("FAIL ones_checksum got=%h want=d0", obs_checksum); end
    $display("test_all_ones: checksum=%h", obs_checksum);
  endtask

  task automatic test_backpressure();
    capture_word({90{1'b1}}, 7, 5);
    for (int s = 0; s < 5; s++) begin
      checks += 3;
      if (stall_valid_obs[s] !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b want=1", s, stall_valid_obs[s]); end
      if (stall_idx_obs[s] !== 5'd7) begin errors++; $display("FAIL stall_idx[%0d] got=%0d want=7", s, stall_idx_obs[s]); end
      if (stall_field_obs[s] !== 8'h1F) begin errors++; $display("FAIL stall_field[%0d] got=%h want=1f", s, stall_field_obs[s]); end
    end
    for (int k = 0; k < 18; k++) begin
      checks += 2;
      if (obs_idx[k] !== 5'(k)) begin errors++; $display("FAIL bp_idx[%0d] got=%0d want=%0d", k, obs_idx[k], k); end
      if (obs_field[k] !== ones_tab[k % 6]) begin errors++; $display("FAIL bp_field[%0d] got=%h want=%h", k, obs_field[k], ones_tab[k % 6]); end
    end
    checks++;
    if (obs_checksum !== 8'hD0) begin errors++; $display("FAIL bp_checksum got=%h want=d0", obs_checksum); end
    $display("test_backpressure: checksum=%h", obs_checksum);
  endtask

  task automatic test_reset_mid_word();
    @(negedge clk);
    in_data   = {90{1'b1}};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int j = 0; j < 10; j++) @(negedge clk);
    checks++;
    if (out_idx !== 5'd9) begin errors++; $display("FAIL abort_idx got=%0d want=9", out_idx); end
    rst = 1'b1;
    @(negedge clk);
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got=%b want=0", out_valid); end
    if (checksum !== 8'h00) begin errors++; $display("FAIL abort_checksum got=%h want=00", checksum); end
    if (out_idx !== 5'd0) begin errors++; $display("FAIL abort_out_idx got=%0d want=0", out_idx); end
    if (out_field !== 8'h00) begin errors++; $display("FAIL abort_out_field got=%h want=00", out_field); end
    rst = 1'b0;
    capture_word({90{1'b1}}, -1, 0);
    checks += 3;
    if (obs_idx[0] !== 5'd0) begin errors++; $display("FAIL after_abort_idx0 got=%0d want=0", obs_idx[0]); end
    if (obs_field[0] !== 8'h0F) begin errors++; $display("FAIL after_abort_field0 got=%h want=0f", obs_field[0]); end
    if (obs_checksum !== 8'hD0) begin errors++; $display("FAIL after_abort_checksum got=%h want=d0", obs_checksum); end
    $display("test_reset_mid_word: checksum=%h", obs_checksum);
  endtask

  task automatic test_back_to_back();
    logic [89:0] d2;
    bit          seen;
    d2 = '0;
    d2[89:86] = 4'hF;
    @(negedge clk);
    in_data   = {90{1'b1}};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_data = d2;
    seen = 1'b0;
    for (int w = 0; w < 30 && !seen; w++) begin
      @(negedge clk);
      seen = sum_valid;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL b2b_first_sum got=timeout want=pulse"); end
    checks++;
    if (checksum !== 8'hD0) begin errors++; $display("FAIL b2b_first_checksum got=%h want=d0", checksum); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready got=%b want=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got=%b want=1", out_valid); end
    if (out_idx !== 5'd0) begin errors++; $display("FAIL b2b_second_idx got=%0d want=0", out_idx); end
    if (out_field !== 8'h0F) begin errors++; $display("FAIL b2b_second_field got=%h want=0f", out_field); end
    seen = 1'b0;
    for (int w = 0; w < 30 && !seen; w++) begin
      @(negedge clk);
      seen = sum_valid;
    end
    checks += 2;
    if (!seen) begin errors++; $display("FAIL b2b_second_sum got=timeout want=pulse"); end
    if (checksum !== 8'h0F) begin errors++; $display("FAIL b2b_second_checksum got=%h want=0f", checksum); end
    @(negedge clk);
    $display("test_back_to_back: checksum=%h", checksum);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    rst = 1'b0;
    test_zeros();
    test_msb_field();
    test_sign_bit();
    test_mixed();
    test_all_ones();
    test_backpressure();
    test_reset_mid_word();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
